// File: rtl/sram_loader_bridge.sv
// UART-to-SRAM boot bridge: loads/dumps SRAM over a byte stream, then
// releases the CPU and hands it the SRAM; 'H' halts it back to the loader.
// Ports: rx_* byte sink, tx_* byte source, cpu_* serv-style bus with
// cpu_rst, mem_* single-port SRAM (read data one cycle after mem_en), busy.
module sram_loader_bridge #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int CPU_ADDR_LSB = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                cpu_rst,
    input  logic [31:0]         cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    input  logic                cpu_cs,
    input  logic                cpu_we,
    input  logic [DATA_W/8-1:0] cpu_wmask,
    output logic                cpu_ack,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    localparam int BYTES = DATA_W / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [3:0] {
        IDLE, W_CNT, W_ADDR, W_DATA, W_MEM, R_CNT,
        R_ADDR, R_MEM, R_WAIT, R_SEND, SEND, RUN
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [BC_W-1:0]     bcnt_q, bcnt_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                go_q, go_d;
    logic                halt_q, halt_d;
    logic                ack_q, rd_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                rx_fire, tx_fire, cpu_req;
    logic [DATA_W+7:0]   shin, shout;
    logic                unused_bits;

    assign rx_fire = rx_valid && rx_ready;
    assign tx_fire = tx_valid_q && tx_ready;
    // Byte streams are little-endian: shift in at the top, out at the bottom.
    assign shin    = {rx_data, word_q};
    assign shout   = {8'h00, word_q};
    // A request is taken only in RUN, never in its own ack cycle, never after 'H'.
    assign cpu_req = (state_q == RUN) && cpu_cs && !ack_q && !halt_q;
    assign unused_bits = ^{cpu_addr, shin[7:0], shout[7:0]};

    assign rx_ready  = rst_n && (state_q inside
                       {IDLE, W_CNT, W_ADDR, W_DATA, R_CNT, R_ADDR, RUN});
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign cpu_rst   = (state_q != RUN);
    assign cpu_ack   = ack_q;
    assign cpu_rdata = (ack_q && rd_q) ? mem_rdata : rdata_q;
    assign busy      = (state_q != IDLE) && (state_q != RUN);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        word_d     = word_q;
        bcnt_d     = bcnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        go_d       = go_q;
        halt_d     = halt_q;
        unique case (state_q)
            IDLE: if (rx_fire) begin
                case (rx_data)
                    8'h57: state_d = W_CNT;
                    8'h52: state_d = R_CNT;
                    8'h47: begin
                        go_d       = 1'b1;
                        tx_data_d  = ACK;
                        tx_valid_d = 1'b1;
                        state_d    = SEND;
                    end
                    default: begin
                        tx_data_d  = NAK;
                        tx_valid_d = 1'b1;
                        state_d    = SEND;
                    end
                endcase
            end
            W_CNT, R_CNT: if (rx_fire) begin
                cnt_d   = rx_data;
                state_d = (state_q == W_CNT) ? W_ADDR : R_ADDR;
            end
            W_ADDR, R_ADDR: if (rx_fire) begin
                addr_d = ADDR_W'(rx_data);
                bcnt_d = '0;
                if (cnt_q == 8'd0) begin
                    tx_data_d  = ACK;
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end else begin
                    state_d = (state_q == W_ADDR) ? W_DATA : R_MEM;
                end
            end
            W_DATA: if (rx_fire) begin
                word_d = shin[DATA_W+7:8];
                if (bcnt_q == BC_W'(BYTES - 1)) begin
                    bcnt_d  = '0;
                    state_d = W_MEM;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            W_MEM: begin
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    tx_data_d  = ACK;
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end else begin
                    state_d = W_DATA;
                end
            end
            R_MEM: state_d = R_WAIT;
            R_WAIT: begin
                word_d     = mem_rdata;
                tx_data_d  = mem_rdata[7:0];
                tx_valid_d = 1'b1;
                bcnt_d     = '0;
                state_d    = R_SEND;
            end
            R_SEND: if (tx_fire) begin
                if (bcnt_q == BC_W'(BYTES - 1)) begin
                    tx_valid_d = 1'b0;
                    addr_d     = addr_q + 1'b1;
                    cnt_d      = cnt_q - 8'd1;
                    state_d    = (cnt_q == 8'd1) ? IDLE : R_MEM;
                end else begin
                    word_d    = shout[DATA_W+7:8];
                    tx_data_d = shout[15:8];
                    bcnt_d    = bcnt_q + 1'b1;
                end
            end
            SEND: if (tx_fire) begin
                tx_valid_d = 1'b0;
                go_d       = 1'b0;
                state_d    = go_q ? RUN : IDLE;
            end
            RUN: begin
                // A halt that lands on an accepted request waits one
                // cycle so that request's ack still completes.
                if (halt_q) begin
                    halt_d     = 1'b0;
                    tx_data_d  = ACK;
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end else if (rx_fire && rx_data == 8'h48) begin
                    if (cpu_req) begin
                        halt_d = 1'b1;
                    end else begin
                        tx_data_d  = ACK;
                        tx_valid_d = 1'b1;
                        state_d    = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_we    = '0;
        mem_wdata = '0;
        if (state_q == W_MEM) begin
            mem_en    = 1'b1;
            mem_addr  = addr_q;
            mem_we    = '1;
            mem_wdata = word_q;
        end else if (state_q == R_MEM) begin
            mem_en   = 1'b1;
            mem_addr = addr_q;
        end else if (cpu_req) begin
            mem_en    = 1'b1;
            mem_addr  = cpu_addr[CPU_ADDR_LSB +: ADDR_W];
            mem_we    = cpu_we ? cpu_wmask : '0;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            bcnt_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            go_q       <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            bcnt_q     <= bcnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            go_q       <= go_d;
            halt_q     <= halt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            rd_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= cpu_req;
            rd_q  <= cpu_req && !cpu_we;
            if (ack_q && rd_q) rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_sram_loader_bridge.sv
// Bench for sram_loader_bridge: 32/5 and 16/8 instances, each with an
// SRAM model; tx bytes are checked against a queue of expected bytes.
module tb_sram_loader_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [7:0] rx_data [2];
    logic       rx_valid [2];
    logic       rx_ready [2];
    logic [7:0] tx_data [2];
    logic       tx_valid [2];
    logic       tx_ready [2];
    logic       cpu_rst [2];
    logic       busy [2];

    logic [31:0] cpu_addr0, cpu_wdata0, cpu_rdata0;
    logic        cpu_cs0, cpu_we0, cpu_ack0;
    logic [3:0]  cpu_wmask0;
    logic        mem_en0;
    logic [4:0]  mem_addr0;
    logic [3:0]  mem_we0;
    logic [31:0] mem_wdata0, mem_rdata0;

    logic [31:0] cpu_addr1;
    logic [15:0] cpu_wdata1, cpu_rdata1;
    logic        cpu_cs1, cpu_we1, cpu_ack1;
    logic [1:0]  cpu_wmask1;
    logic        mem_en1;
    logic [7:0]  mem_addr1;
    logic [1:0]  mem_we1;
    logic [15:0] mem_wdata1, mem_rdata1;

    sram_loader_bridge #(.DATA_W(32), .ADDR_W(5), .CPU_ADDR_LSB(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .cpu_rst(cpu_rst[0]), .cpu_addr(cpu_addr0), .cpu_wdata(cpu_wdata0),
        .cpu_rdata(cpu_rdata0), .cpu_cs(cpu_cs0), .cpu_we(cpu_we0),
        .cpu_wmask(cpu_wmask0), .cpu_ack(cpu_ack0),
        .mem_en(mem_en0), .mem_addr(mem_addr0), .mem_we(mem_we0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .busy(busy[0])
    );

    sram_loader_bridge #(.DATA_W(16), .ADDR_W(8), .CPU_ADDR_LSB(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .cpu_rst(cpu_rst[1]), .cpu_addr(cpu_addr1), .cpu_wdata(cpu_wdata1),
        .cpu_rdata(cpu_rdata1), .cpu_cs(cpu_cs1), .cpu_we(cpu_we1),
        .cpu_wmask(cpu_wmask1), .cpu_ack(cpu_ack1),
        .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_we(mem_we1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy[1])
    );

    logic [31:0] mem0 [32];
    logic [15:0] mem1 [256];
    int en_cnt0 = 0;

    always @(posedge clk) begin
        if (mem_en0) begin
            en_cnt0 <= en_cnt0 + 1;
            mem_rdata0 <= mem0[mem_addr0];
            for (int b = 0; b < 4; b++)
                if (mem_we0[b]) mem0[mem_addr0][8*b +: 8] <= mem_wdata0[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (mem_en1) begin
            mem_rdata1 <= mem1[mem_addr1];
            for (int b = 0; b < 2; b++)
                if (mem_we1[b]) mem1[mem_addr1][8*b +: 8] <= mem_wdata1[8*b +: 8];
        end
    end

    int nvec = 0;
    int nerr = 0;
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void expect_tx(input int d, input logic [7:0] b);
        if (d == 0) q0.push_back(b);
        else q1.push_back(b);
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    logic       stall [2] = '{1'b0, 1'b0};
    logic [7:0] held [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (stall[d] && tx_valid[d]) check("tx_hold", tx_data[d], held[d]);
            stall[d] = tx_valid[d] && !tx_ready[d];
            held[d]  = tx_data[d];
            if (tx_valid[d] && tx_ready[d]) begin
                if (qsize(d) == 0) check("tx_extra", tx_data[d], 64'h1FF);
                else if (d == 0) check("tx0", tx_data[d], q0.pop_front());
                else check("tx1", tx_data[d], q1.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int d, input logic [7:0] b);
        int n = 0;
        rx_data[d]  = b;
        rx_valid[d] = 1'b1;
        @(negedge clk);
        while (!rx_ready[d] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready[d]) check("rx_timeout", 0, 1);
        @(posedge clk);
        #1;
        rx_valid[d] = 1'b0;
    endtask

    task automatic send_list(input int d, input logic [7:0] s [$]);
        foreach (s[i]) send_byte(d, s[i]);
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        @(negedge clk);
        while (n < 2000 && !(qsize(d) == 0 && !busy[d] && !tx_valid[d])) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("idle_timeout", qsize(d), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run(input int d);
        int n = 0;
        while (cpu_rst[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("run_cpu_rst", cpu_rst[d], 0);
        check("ack_before_run", qsize(d), 0);
        cyc(1);
    endtask

    logic [7:0] seq [$];
    int e, acks;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rx_data[d] = 8'h00; rx_valid[d] = 1'b0; tx_ready[d] = 1'b1;
        end
        cpu_addr0 = '0; cpu_wdata0 = '0; cpu_cs0 = 1'b0; cpu_we0 = 1'b0;
        cpu_wmask0 = '0;
        cpu_addr1 = '0; cpu_wdata1 = '0; cpu_cs1 = 1'b0; cpu_we1 = 1'b0;
        cpu_wmask1 = '0;
        rst_n = 1'b0;
        cyc(3);
        check("rst_cpu_rst", cpu_rst[0], 1);
        check("rst_mem_en", mem_en0, 0);
        check("rst_rx_ready", rx_ready[0], 0);
        check("rst_tx_valid", tx_valid[0], 0);
        check("rst_busy", busy[0], 0);
        rst_n = 1'b1;
        cyc(2);
        check("idle_rx_ready", rx_ready[0], 1);

        seq = '{8'h57, 8'h01, 8'h03, 8'hA1, 8'hB2};
        send_list(0, seq);
        check("mid_w_busy", busy[0], 1);
        rst_n = 1'b0;
        #1;
        check("rst2_cpu_rst", cpu_rst[0], 1);
        check("rst2_mem_en", mem_en0, 0);
        check("rst2_busy", busy[0], 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(6);
        check("no_partial_write", en_cnt0, 0);

        expect_tx(0, 8'h06);
        send_byte(0, 8'h47);
        check("g_rst_held", cpu_rst[0], 1);
        wait_run(0);
        expect_tx(0, 8'h06);
        send_byte(0, 8'h48);
        check("h_cpu_rst", cpu_rst[0], 1);
        wait_idle(0);

        expect_tx(0, 8'h06);
        seq = '{8'h57, 8'h02, 8'h1E, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88};
        send_list(0, seq);
        wait_idle(0);
        check("wr_1e", mem0[30], 32'h44332211);
        check("wr_1f", mem0[31], 32'h88776655);

        for (int i = 1; i <= 8; i++) expect_tx(0, 8'(8'h11 * i));
        seq = '{8'h52, 8'h02, 8'h1E};
        send_list(0, seq);
        wait_idle(0);

        expect_tx(0, 8'h06);
        seq = '{8'h57, 8'h03, 8'h1F};
        for (int i = 0; i < 12; i++) seq.push_back(8'(i));
        send_list(0, seq);
        wait_idle(0);
        check("wrap_1f", mem0[31], 32'h03020100);
        check("wrap_00", mem0[0], 32'h07060504);
        check("wrap_01", mem0[1], 32'h0B0A0908);

        expect_tx(0, 8'h06);
        seq = '{8'h57, 8'h01, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_list(0, seq);
        wait_idle(0);
        expect_tx(0, 8'h06);
        seq = '{8'h57, 8'h01, 8'h04, 8'h11, 8'h11, 8'h11, 8'h11};
        send_list(0, seq);
        wait_idle(0);

        expect_tx(0, 8'h06);
        send_byte(0, 8'h47);
        wait_run(0);

        cpu_cs0 = 1'b1; cpu_we0 = 1'b0; cpu_addr0 = 32'h8;
        #1;
        check("rd_mem_en", mem_en0, 1);
        check("rd_mem_addr", mem_addr0, 2);
        check("rd_mem_we", mem_we0, 0);
        @(posedge clk);
        #1;
        cpu_cs0 = 1'b0;
        check("rd_ack", cpu_ack0, 1);
        check("rd_data", cpu_rdata0, 32'hDEADBEEF);
        cyc(1);
        check("rd_ack_once", cpu_ack0, 0);
        check("rd_data_held", cpu_rdata0, 32'hDEADBEEF);

        cpu_cs0 = 1'b1; cpu_we0 = 1'b1; cpu_wmask0 = 4'b0100;
        cpu_addr0 = 32'h10; cpu_wdata0 = 32'hAACCBBDD;
        #1;
        check("wr_mem_we", mem_we0, 4'b0100);
        check("wr_mem_addr", mem_addr0, 4);
        check("wr_mem_wdata", mem_wdata0, 32'hAACCBBDD);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (i == 1) cpu_cs0 = 1'b0;
            acks += int'(cpu_ack0);
        end
        cpu_we0 = 1'b0;
        check("wr_one_ack", acks, 1);
        check("wr_mask_mem", mem0[4], 32'h11CC1111);
        check("wr_rdata_held", cpu_rdata0, 32'hDEADBEEF);

        expect_tx(0, 8'h06);
        cpu_cs0 = 1'b1; cpu_addr0 = 32'h8;
        rx_data[0] = 8'h48; rx_valid[0] = 1'b1;
        cyc(1);
        rx_valid[0] = 1'b0; cpu_cs0 = 1'b0;
        check("halt_ack", cpu_ack0, 1);
        check("halt_rst_late", cpu_rst[0], 0);
        check("halt_rdata", cpu_rdata0, 32'hDEADBEEF);
        cyc(1);
        check("halt_rst", cpu_rst[0], 1);
        check("halt_no_ack", cpu_ack0, 0);
        wait_idle(0);

        expect_tx(0, 8'h15);
        send_byte(0, 8'h99);
        wait_idle(0);

        e = en_cnt0;
        expect_tx(0, 8'h06);
        seq = '{8'h57, 8'h00, 8'h05};
        send_list(0, seq);
        wait_idle(0);
        expect_tx(0, 8'h06);
        seq = '{8'h52, 8'h00, 8'h05};
        send_list(0, seq);
        wait_idle(0);
        check("cnt0_no_mem", en_cnt0, e);

        expect_tx(1, 8'h06);
        seq = '{8'h57, 8'h01, 8'hFF, 8'hAA, 8'hBB};
        send_list(1, seq);
        wait_idle(1);
        check("w16_ff", mem1[255], 16'hBBAA);

        tx_ready[1] = 1'b0;
        expect_tx(1, 8'hAA);
        expect_tx(1, 8'hBB);
        seq = '{8'h52, 8'h01, 8'hFF};
        send_list(1, seq);
        for (int k = 0; k < 2; k++) begin
            int n = 0;
            while (!tx_valid[1] && n < 200) begin
                cyc(1);
                n++;
            end
            check("bp_valid", tx_valid[1], 1);
            cyc(10);
            tx_ready[1] = 1'b1;
            cyc(1);
            tx_ready[1] = 1'b0;
        end
        tx_ready[1] = 1'b1;
        wait_idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sram_loader_bridge.md
Name: sram_loader_bridge

Overview:
Parametrised UART-to-SRAM boot bridge sitting between the UART RX/TX pair, the single-port SRAM macro and the serv CPU bus. It extends the existing load-then-run controller in four ways:
- configurable word and address widths;
- a read-back (dump) command;
- halt/re-run of the CPU without a chip reset;
- explicit ACK/NAK responses.

It owns the CPU reset and arbitrates SRAM access: the loader has the SRAM while the CPU is held, and the CPU has it while running.

Parameters:
- DATA_W, 32, SRAM word width in bits; must be a multiple of 8. BYTES = DATA_W/8 (derived).
- ADDR_W, 5, SRAM word-address width; DEPTH = 2**ADDR_W words.
- CPU_ADDR_LSB, 2, lowest CPU byte-address bit used as word address; the word address is cpu_addr[CPU_ADDR_LSB +: ADDR_W].

Ports:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- rx_data, in, 8, received byte.
- rx_valid, in, 1, rx_data valid.
- rx_ready, out, 1, bridge accepts a byte; a byte transfers when rx_valid && rx_ready.
- tx_data, out, 8, byte to send.
- tx_valid, out, 1, tx_data valid.
- tx_ready, in, 1, transmitter accepts; a byte transfers when tx_valid && tx_ready.
- cpu_rst, out, 1, active-high CPU reset.
- cpu_addr, in, 32, CPU byte address.
- cpu_wdata, in, DATA_W, CPU write data.
- cpu_rdata, out, DATA_W, CPU read data.
- cpu_cs, in, 1, CPU request.
- cpu_we, in, 1, CPU write.
- cpu_wmask, in, BYTES, CPU byte enables.
- cpu_ack, out, 1, one-cycle completion pulse.
- mem_en, out, 1, SRAM enable.
- mem_addr, out, ADDR_W, SRAM word address.
- mem_we, out, BYTES, SRAM byte write enables.
- mem_wdata, out, DATA_W, SRAM write data.
- mem_rdata, in, DATA_W, SRAM read data, valid the cycle after mem_en.
- busy, out, 1, high whenever the FSM is not in IDLE or RUN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; cpu_rst=1.
  - All other outputs 0: rx_ready, tx_valid, tx_data, cpu_ack, cpu_rdata, mem_*, busy.
  - Internal count, address and shift registers are cleared. Any transfer in progress is abandoned; no partial write is committed.
- rx_ready is 1 in IDLE, W_CNT, W_ADDR, W_DATA, R_CNT, R_ADDR and RUN; it is 0 in all other states.
- tx_valid/tx_data are held stable until tx_ready is sampled high.
- Commands, accepted in IDLE:
  - 0x57 'W' count addr data...: count N (1..255) words starting at word address addr[ADDR_W-1:0], followed by N*BYTES data bytes, least significant byte first.
  - 0x52 'R' count addr: returns N*BYTES bytes, least significant byte first.
  - 0x47 'G': sends 0x06, then goes to RUN with cpu_rst=0.
  - Any other byte: sends 0x15 (NAK) and stays in IDLE.
  - A count of 0 on W or R: no memory access; send 0x06 and return to IDLE.
- FSM states: IDLE, W_CNT, W_ADDR, W_DATA, W_MEM, R_CNT, R_ADDR, R_MEM, R_WAIT, R_SEND, SEND, RUN.
- W_DATA: shift bytes into the word register. After BYTES bytes, go to W_MEM.
- W_MEM: one cycle with mem_en=1, mem_we=all ones, and mem_addr at the current address. Then address += 1 (mod DEPTH, wrapping) and count -= 1. If count is now 0, go to SEND with 0x06; otherwise return to W_DATA.
- R_MEM: mem_en=1, mem_we=0.
- R_WAIT: capture mem_rdata.
- R_SEND: emit BYTES bytes, least significant first. Then address += 1 (wrapping) and count -= 1. If count is 0, return to IDLE (no trailing ACK); otherwise go to R_MEM.
- SEND: hold the response byte until accepted, then go to IDLE (or to RUN after 'G').
- RUN state:
  - Loader bytes other than 0x48 'H' are consumed and ignored.
  - CPU access: cpu_cs sampled high in cycle t drives mem_en=1, mem_addr from cpu_addr, mem_we = cpu_we ? cpu_wmask : 0, and mem_wdata=cpu_wdata in cycle t.
  - In cycle t+1: cpu_ack=1; for reads, cpu_rdata=mem_rdata. cpu_rdata is held until the next read completes.
  - cpu_cs is ignored in the cycle cpu_ack is high, giving exactly one ack per request.
- 'H' in RUN:
  - If no access is in flight: cpu_rst=1 on the next cycle, send 0x06, return to IDLE.
  - If 'H' arrives in cycle t of a CPU access: the ack in t+1 still completes, and cpu_rst asserts in t+2.
  - No new CPU request is accepted after 'H' is consumed.
- Outside RUN: cpu_ack=0, and CPU requests never reach the SRAM.

Test Plan:
- Reset with ACK: rst_n low mid-W_DATA, then high → cpu_rst=1, mem_en=0, no write; then 0x47 → tx 0x06, cpu_rst falls after tx_ready.
- Write then read back: W 2 @0x1E with bytes 11 22 33 44 55 66 77 88 → mem[0x1E]=0x44332211, mem[0x1F]=0x88776655. Then R 2 @0x1E → tx 11 22 33 44 55 66 77 88.
- Address wrap: W 3 @0x1F (ADDR_W=5) → words written to addresses 0x1F, 0x00, 0x01; tx 0x06.
- CPU access in RUN: cpu_cs read at addr 0x08 with mem[2]=0xDEADBEEF → cpu_ack one cycle later, cpu_rdata=0xDEADBEEF. Write with wmask 0b0100 → mem_we=0b0100; exactly one ack while cs is held.
- Halt and NAK: 0x48 during a CPU access → ack completes, cpu_rst=1 the following cycle, tx 0x06. Then 0x99 in IDLE → tx 0x15. Then W with count 0 → tx 0x06, no mem_en.
- Width parameters: DATA_W=16, ADDR_W=8 → W 1 @0xFF with bytes AA BB → mem[0xFF]=0xBBAA; R 1 @0xFF → tx AA BB; tx backpressure (tx_ready low 10 cycles) holds each byte stable.
